// File: rtl/seq_pkg.sv
// Shared types and constants for the Y86-64 SEQ multi-cycle sequencer.
// Imported by the controller and its helper blocks.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_t;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_t;

    // Instructions that touch data memory in the MEMORY stage.
    function automatic logic is_mem_icode(input logic [3:0] icode);
        case (icode)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: is_mem_icode = 1'b1;
            default:                                      is_mem_icode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on a memory request; o_expired flags the
// TIMEOUT-1 count so the owner can abort the access on the next edge.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/seq_ctrl.sv
// Y86-64 SEQ multi-cycle sequencer: per-stage enables, shared memory
// arbitration between fetch and data, status, run/step control, counters.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             fetch_en,
    output logic             dec_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [1:0]       stat,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    stat_t            r_stat;
    stat_t            w_stat_nxt;
    logic [3:0]       r_icode;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_mem_access;
    logic w_waiting;
    logic w_expired;
    logic w_retire;

    // Data access decision uses the icode captured at the fetch ack, never the live input.
    assign w_mem_access = is_mem_icode(r_icode);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (!w_waiting),
        .i_en      (w_waiting),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_stat  <= STAT_AOK;
            r_icode <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stat  <= w_stat_nxt;
            if (r_state == S_FETCH && mem_ack) begin
                r_icode <= icode;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_stat_nxt  = r_stat;
        w_waiting   = 1'b0;
        w_retire    = 1'b0;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        fetch_en    = 1'b0;
        dec_en      = 1'b0;
        exe_en      = 1'b0;
        mem_en      = 1'b0;
        wb_en       = 1'b0;
        pc_en       = 1'b0;
        halted      = 1'b0;
        busy        = 1'b1;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (run || step) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                fetch_en  = 1'b1;
                mem_req   = 1'b1;
                w_waiting = 1'b1;
                if (mem_ack) begin
                    if (imem_error) begin
                        w_stat_nxt  = STAT_ADR;
                        w_state_nxt = S_HALT;
                    end else if (!instr_valid) begin
                        w_stat_nxt  = STAT_INS;
                        w_state_nxt = S_HALT;
                    end else if (icode == IHALT) begin
                        w_stat_nxt  = STAT_HLT;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_DECODE;
                    end
                end else if (w_expired) begin
                    w_stat_nxt  = STAT_ADR;
                    w_state_nxt = S_HALT;
                end
            end

            S_DECODE: begin
                dec_en      = 1'b1;
                w_state_nxt = S_EXECUTE;
            end

            S_EXECUTE: begin
                exe_en      = 1'b1;
                w_state_nxt = S_MEMORY;
            end

            S_MEMORY: begin
                mem_en = 1'b1;
                if (w_mem_access) begin
                    mem_req   = 1'b1;
                    mem_sel   = 1'b1;
                    w_waiting = 1'b1;
                    if (mem_ack) begin
                        if (dmem_error) begin
                            w_stat_nxt  = STAT_ADR;
                            w_state_nxt = S_HALT;
                        end else begin
                            w_state_nxt = S_WRITEBACK;
                        end
                    end else if (w_expired) begin
                        w_stat_nxt  = STAT_ADR;
                        w_state_nxt = S_HALT;
                    end
                end else begin
                    w_state_nxt = S_WRITEBACK;
                end
            end

            S_WRITEBACK: begin
                wb_en       = 1'b1;
                w_state_nxt = S_PCUPD;
            end

            S_PCUPD: begin
                pc_en       = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = run ? S_FETCH : S_IDLE;
            end

            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end

            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (busy && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_retire && (r_instr_cnt != '1)) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign stat      = r_stat;
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: directed scenarios push the expected per-cycle
// stage trace and final status; a negedge monitor pops and compares.
module tb_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic        dmem_error;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_sel;
    logic        fetch_en;
    logic        dec_en;
    logic        exe_en;
    logic        mem_en;
    logic        wb_en;
    logic        pc_en;
    logic [1:0]  stat;
    logic        halted;
    logic        busy;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    seq_ctrl #(
        .TIMEOUT (16),
        .CNT_W   (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_sel     (mem_sel),
        .fetch_en    (fetch_en),
        .dec_en      (dec_en),
        .exe_en      (exe_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .pc_en       (pc_en),
        .stat        (stat),
        .halted      (halted),
        .busy        (busy),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trace word: {fetch,dec,exe,mem,wb,pc,mem_req,mem_sel}
    localparam logic [7:0] T_F  = 8'b1000_0010;
    localparam logic [7:0] T_D  = 8'b0100_0000;
    localparam logic [7:0] T_E  = 8'b0010_0000;
    localparam logic [7:0] T_M  = 8'b0001_0000;
    localparam logic [7:0] T_MR = 8'b0001_0011;
    localparam logic [7:0] T_W  = 8'b0000_1000;
    localparam logic [7:0] T_P  = 8'b0000_0100;

    typedef struct {
        logic [1:0]  stat;
        logic        halted;
        logic [31:0] cyc;
        logic [31:0] ins;
    } status_t;

    logic [7:0] exp_q[$];
    status_t    st_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int trace_idx = 0;

    int  i_delay   = 0;
    int  d_delay   = 0;
    int  resp_wait = 0;
    bit  ack_never = 1'b0;
    bit  stale_ack = 1'b0;

    logic [7:0] mon_obs;
    logic [7:0] mon_exp;
    status_t    mon_st;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One instruction's expected trace: fetch waits fw cycles, data access waits dw.
    task automatic push_instr(input bit memop, input int fw, input int dw);
        for (int k = 0; k <= fw; k++) exp_q.push_back(T_F);
        exp_q.push_back(T_D);
        exp_q.push_back(T_E);
        if (memop) begin
            for (int k = 0; k <= dw; k++) exp_q.push_back(T_MR);
        end else begin
            exp_q.push_back(T_M);
        end
        exp_q.push_back(T_W);
        exp_q.push_back(T_P);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset       = 1'b1;
        run         = 1'b0;
        step        = 1'b0;
        icode       = 4'h0;
        instr_valid = 1'b1;
        imem_error  = 1'b0;
        dmem_error  = 1'b0;
        ack_never   = 1'b0;
        stale_ack   = 1'b0;
        i_delay     = 0;
        d_delay     = 0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        st_q.delete();
    endtask

    task automatic wait_settle();
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("settle_not_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic expect_status(input logic [1:0] s, input logic h,
                                 input logic [31:0] cyc, input logic [31:0] ins);
        status_t e;
        wait_settle();
        check("trace_drained", 32'(exp_q.size()), 32'd0);
        e.stat   = s;
        e.halted = h;
        e.cyc    = cyc;
        e.ins    = ins;
        st_q.push_back(e);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Memory responder: acks the live request after the configured wait.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_req && !ack_never) begin
                if (resp_wait >= (mem_sel ? d_delay : i_delay)) begin
                    mem_ack   = 1'b1;
                    resp_wait = 0;
                end else begin
                    mem_ack = 1'b0;
                    resp_wait++;
                end
            end else begin
                mem_ack   = stale_ack;
                resp_wait = 0;
            end
        end
    end

    // Monitor: compares every busy cycle against the trace queue and any
    // pending status expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_obs = {fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en, mem_req, mem_sel};
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL trace_extra[%0d] got %b want no busy cycle (t=%0t)",
                                 trace_idx, mon_obs, $time);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check($sformatf("trace[%0d]", trace_idx), 32'(mon_obs), 32'(mon_exp));
                    end
                    trace_idx++;
                end
                if (st_q.size() > 0) begin
                    mon_st = st_q.pop_front();
                    check("stat", 32'(stat), 32'(mon_st.stat));
                    check("halted", 32'(halted), 32'(mon_st.halted));
                    check("busy", 32'(busy), 32'd0);
                    check("quiet_outputs", 32'(mon_obs), 32'd0);
                    check("cycle_cnt", cycle_cnt, mon_st.cyc);
                    check("instr_cnt", instr_cnt, mon_st.ins);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        run = 1'b0; step = 1'b0; icode = 4'h0;
        instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;

        // Reset state
        do_reset();
        expect_status(2'b00, 1'b0, 32'd0, 32'd0);

        // Three OPq instructions back to back, run dropped during the third
        do_reset();
        icode = 4'h6;
        for (int k = 0; k < 3; k++) push_instr(1'b0, 0, 0);
        run = 1'b1;
        repeat (14) @(posedge clk); #1;
        run = 1'b0;
        expect_status(2'b00, 1'b0, 32'd18, 32'd3);

        // mrmovq with a 3-cycle data wait, then halt
        do_reset();
        icode = 4'h5;
        d_delay = 3;
        push_instr(1'b1, 0, 3);
        exp_q.push_back(T_F);
        run = 1'b1;
        repeat (5) @(posedge clk); #1;
        icode = 4'h0;
        expect_status(2'b01, 1'b1, 32'd10, 32'd1);

        // Invalid instruction outranks halt
        do_reset();
        icode = 4'h0;
        instr_valid = 1'b0;
        exp_q.push_back(T_F);
        run = 1'b1;
        expect_status(2'b11, 1'b1, 32'd1, 32'd0);

        // Fetch address error outranks invalid instruction
        do_reset();
        imem_error = 1'b1;
        instr_valid = 1'b0;
        exp_q.push_back(T_F);
        run = 1'b1;
        expect_status(2'b10, 1'b1, 32'd1, 32'd0);

        // rmmovq with data error on the ack: no writeback, no PC update
        do_reset();
        icode = 4'h4;
        dmem_error = 1'b1;
        exp_q.push_back(T_F);
        exp_q.push_back(T_D);
        exp_q.push_back(T_E);
        exp_q.push_back(T_MR);
        run = 1'b1;
        expect_status(2'b10, 1'b1, 32'd4, 32'd0);

        // Fetch never acked: 16 request cycles, then ADR
        do_reset();
        icode = 4'h6;
        ack_never = 1'b1;
        for (int k = 0; k < 16; k++) exp_q.push_back(T_F);
        run = 1'b1;
        expect_status(2'b10, 1'b1, 32'd16, 32'd0);

        // Single step with a 2-cycle fetch wait; second pulse while busy is ignored
        do_reset();
        icode = 4'h1;
        i_delay = 2;
        push_instr(1'b0, 2, 0);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (3) @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        expect_status(2'b00, 1'b0, 32'd8, 32'd1);

        // Reset during a data wait, then a stale ack while idle
        do_reset();
        icode = 4'h5;
        d_delay = 10;
        exp_q.push_back(T_F);
        exp_q.push_back(T_D);
        exp_q.push_back(T_E);
        exp_q.push_back(T_MR);
        exp_q.push_back(T_MR);
        run = 1'b1;
        repeat (6) @(posedge clk); #1;
        reset = 1'b1;
        run = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        stale_ack = 1'b1;
        repeat (4) @(posedge clk); #1;
        stale_ack = 1'b0;
        expect_status(2'b00, 1'b0, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
Multi-cycle sequencer for the Y86-64 SEQ datapath. It replaces the free-running clock-per-instruction scheme with explicit per-stage enables: fetch, decode, execute, memory, writeback and PC update. It arbitrates one shared single-port memory between instruction fetch and data access. It also owns the processor status, run/single-step control and performance counters.

Parameters:
TIMEOUT, 16, max cycles to wait for mem_ack before declaring an address error
CNT_W, 32, width of cycle and instruction counters

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = execute instructions continuously
step  input  1  one-cycle pulse; execute exactly one instruction while run=0
icode  input  4  instruction code from fetch, valid from the cycle mem_ack is accepted in FETCH
instr_valid  input  1  fetch decode-valid flag
imem_error  input  1  fetch address error
dmem_error  input  1  data memory address error, sampled with mem_ack in MEMORY
mem_ack  input  1  shared memory completion
mem_req  output  1  shared memory request
mem_sel  output  1  0 = instruction port owns memory, 1 = data port
fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en  output  1 each  stage enables, one-cycle pulses
stat  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS
halted  output  1  1 in HALT state
busy  output  1  1 in any state other than IDLE/HALT
cycle_cnt  output  CNT_W  busy cycles, saturating
instr_cnt  output  CNT_W  retired instructions, saturating

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Reset (any state, including mid-instruction or mid-memory-wait) forces the following on the next edge:
  - state=IDLE, stat=AOK, counters=0.
  - All enables, mem_req, mem_sel, halted and busy = 0.
  - Any outstanding memory access is abandoned; a late mem_ack is ignored.
- IDLE: go to FETCH if run=1, or if step=1. step is ignored outside IDLE.
- FETCH:
  - mem_req=1, mem_sel=0, fetch_en=1 in every FETCH cycle.
  - mem_ack may arrive in the same cycle as mem_req.
  - On the ack cycle, classify in priority order:
    - imem_error → stat=ADR, HALT.
    - !instr_valid → stat=INS, HALT.
    - icode==0 (halt) → stat=HLT, HALT.
    - otherwise → DECODE.
- DECODE → EXECUTE → MEMORY, one cycle each; dec_en and exe_en pulse in their respective states.
- MEMORY:
  - mem_en=1.
  - For memory icodes (4 rmmovq, 5 mrmovq, 8 call, 9 ret, A pushq, B popq): mem_req=1, mem_sel=1; wait for mem_ack.
    - dmem_error on ack → stat=ADR, HALT (no WB, no PC update).
    - otherwise → WRITEBACK.
  - For other icodes: no request, single cycle → WRITEBACK.
  - The icode used is the one latched on the FETCH ack.
- WRITEBACK: wb_en=1, then PCUPD.
- PCUPD:
  - pc_en=1; instr_cnt increments (saturating at all-ones).
  - Next state: FETCH if run=1, else IDLE.
- Timeout: a wait counter starts at 0 on entering FETCH or a memory-access MEMORY state. If it reaches TIMEOUT-1 with no ack, set stat=ADR and go to HALT on the next edge.
- HALT: exits only through reset; outputs halted=1, all enables=0, mem_req=0; stat holds.
- cycle_cnt increments in every busy cycle, saturating.
- Minimum latency is 6 cycles per instruction with same-cycle acks; each wait cycle adds 1.
- mem_sel and the enables decode from registered state only. mem_req is also state-decoded.
- Dropping run mid-instruction completes that instruction, then enters IDLE.

Decomposition:
- Package seq_pkg holds:
  - state enum;
  - stat codes (AOK/HLT/ADR/INS);
  - icode constants (IHALT=0 … IPOPQ=B);
  - a function is_mem_icode(icode).
- One natural sub-module: mem_wait_timer. It is the TIMEOUT counter with clear/enable and an expired output, reusable by the future pipelined controller.

Test Plan:
- Reset, run=1, always-ack memory, icode=6 (OPq) for 3 instructions:
  - Enables pulse in order F,D,E,M,W,P with period 6.
  - instr_cnt=3 after 18 busy cycles; cycle_cnt=18.
  - mem_sel is never 1.
- mrmovq (icode 5), ack delayed 3 cycles in MEMORY:
  - mem_sel=1 for 4 cycles; instruction takes 9 cycles.
  - Then icode 0 → stat=01, halted=1, instr_cnt=1.
- Fetch ack with instr_valid=0 → stat=11, HALT, no pc_en pulse.
- rmmovq with dmem_error on ack → stat=10, no wb_en/pc_en pulse.
- No mem_ack in FETCH, TIMEOUT=16 → stat=10 on the edge after 16 request cycles.
- Step and reset checks:
  - run=0, single step pulse → exactly one instruction then IDLE, instr_cnt=1.
  - A second step pulse issued during busy is ignored.
  - Reset asserted during a MEMORY wait → IDLE, counters 0, stat=00; a stale ack afterwards is ignored.
